// File: rtl/btn_debounce_if.sv
// Signal bundle between a push-button source and the debounce stage.
// The master side owns the raw button and the clear request; the slave
// side (the debouncer) owns the conditioned level, pulses and press count.
`timescale 1ns/1ps

interface btn_debounce_if;
    logic       btn_in;
    logic       clr;
    logic       btn_level;
    logic       btn_rise;
    logic       btn_fall;
    logic [7:0] press_cnt;

    modport master (
        output btn_in,
        output clr,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  press_cnt
    );

    modport slave (
        input  btn_in,
        input  clr,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output press_cnt
    );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, then a four-state
// stability FSM that only accepts a new level after CNT_MAX consecutive
// synchronized samples disagree with the current one. Produces a clean
// registered level, one-cycle rise/fall pulses and a modulo-256 press count.
`timescale 1ns/1ps

module btn_debounce #(
    parameter int CNT_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    btn_debounce_if.slave  bus
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } state_t;

    logic          s1;
    logic          s2;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          commit_rise;
    logic          commit_fall;

    logic          level_q;
    logic          rise_q;
    logic          fall_q;
    logic [7:0]    press_q;
    logic          level_next;
    logic          rise_next;
    logic          fall_next;
    logic [7:0]    press_next;

    // Bring the asynchronous button into the clk domain before anything looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.btn_in;
            s2 <= s1;
        end
    end

    // FSM state and stability counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE_LO;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: a WAIT state counts agreeing samples and commits on the last one.
    always_comb begin
        state_next  = state;
        cnt_next    = '0;
        commit_rise = 1'b0;
        commit_fall = 1'b0;
        unique case (state)
            STABLE_LO: begin
                if (s2) begin
                    state_next = WAIT_HI;
                    cnt_next   = CW'(1);
                end
            end
            WAIT_HI: begin
                if (!s2) begin
                    state_next = STABLE_LO;
                end else if (cnt == CNT_LAST) begin
                    state_next  = STABLE_HI;
                    commit_rise = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            STABLE_HI: begin
                if (!s2) begin
                    state_next = WAIT_LO;
                    cnt_next   = CW'(1);
                end
            end
            WAIT_LO: begin
                if (s2) begin
                    state_next = STABLE_HI;
                end else if (cnt == CNT_LAST) begin
                    state_next  = STABLE_LO;
                    commit_fall = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = STABLE_LO;
            end
        endcase
    end

    // Output logic: pulses follow commits, and a clear outranks a rise in the press count.
    always_comb begin
        level_next = level_q;
        rise_next  = commit_rise;
        fall_next  = commit_fall;
        press_next = press_q;
        if (commit_rise) begin
            level_next = 1'b1;
        end else if (commit_fall) begin
            level_next = 1'b0;
        end
        if (bus.clr) begin
            press_next = 8'd0;
        end else if (commit_rise) begin
            press_next = press_q + 8'd1;
        end
    end

    // Register every output so nothing downstream sees a combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= 8'd0;
        end else begin
            level_q <= level_next;
            rise_q  <= rise_next;
            fall_q  <= fall_next;
            press_q <= press_next;
        end
    end

    assign bus.btn_level = level_q;
    assign bus.btn_rise  = rise_q;
    assign bus.btn_fall  = fall_q;
    assign bus.press_cnt = press_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: a table of hand-derived vectors,
// hand-written reset / wrap / clear sequences, and random button activity,
// with every edge compared against a sample-history reference model.
`timescale 1ns/1ps

module tb_btn_debounce;

    localparam int CNT_MAX = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    btn_debounce_if bus ();

    btn_debounce #(.CNT_MAX(CNT_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit       btn;
        bit       clr;
        int       cycles;
        bit       lvl;
        bit       rise;
        bit       fall;
        bit [7:0] press;
    } vec_t;

    vec_t vecs[10];

    // Reference model: synchronizer as a two-deep delay queue, debounce as
    // "the last CNT_MAX samples since the previous commit all disagree".
    bit       m_level;
    bit       m_rise;
    bit       m_fall;
    bit [7:0] m_press;
    bit       sync_q[$];
    bit       run_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        m_level = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_press = 8'd0;
        sync_q.delete();
        sync_q.push_back(1'b0);
        sync_q.push_back(1'b0);
        run_q.delete();
    endtask

    task automatic modelStep(input bit b, input bit c);
        bit s;
        s = sync_q.pop_front();
        sync_q.push_back(b);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_level) run_q.push_back(s);
        else run_q.delete();
        if (run_q.size() == CNT_MAX) begin
            m_level = ~m_level;
            if (m_level) m_rise = 1'b1;
            else m_fall = 1'b1;
            run_q.delete();
        end
        if (c) m_press = 8'd0;
        else if (m_rise) m_press = m_press + 8'd1;
    endtask

    task automatic checkOutput(input string name, input bit l, input bit r,
                               input bit f, input bit [7:0] p);
        checks++;
        if (bus.btn_level !== l || bus.btn_rise !== r || bus.btn_fall !== f || bus.press_cnt !== p) begin
            failures++;
            $display("[TB] FAIL %s: got level=%0b rise=%0b fall=%0b press=%0d, expected level=%0b rise=%0b fall=%0b press=%0d",
                     name, bus.btn_level, bus.btn_rise, bus.btn_fall, bus.press_cnt, l, r, f, p);
        end
    endtask

    task automatic applyStimulus(input bit b, input bit c);
        bus.btn_in = b;
        bus.clr    = c;
        @(posedge clk);
        modelStep(b, c);
        #1;
        checkOutput("model", m_level, m_rise, m_fall, m_press);
    endtask

    task automatic doPress();
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0] = '{btn:1'b0, clr:1'b0, cycles:9,  lvl:1'b0, rise:1'b0, fall:1'b0, press:8'd0};
        vecs[1] = '{btn:1'b1, clr:1'b0, cycles:6,  lvl:1'b1, rise:1'b1, fall:1'b0, press:8'd1};
        vecs[2] = '{btn:1'b1, clr:1'b0, cycles:1,  lvl:1'b1, rise:1'b0, fall:1'b0, press:8'd1};
        vecs[3] = '{btn:1'b1, clr:1'b0, cycles:13, lvl:1'b1, rise:1'b0, fall:1'b0, press:8'd1};
        vecs[4] = '{btn:1'b0, clr:1'b0, cycles:6,  lvl:1'b0, rise:1'b0, fall:1'b1, press:8'd1};
        vecs[5] = '{btn:1'b0, clr:1'b0, cycles:1,  lvl:1'b0, rise:1'b0, fall:1'b0, press:8'd1};
        vecs[6] = '{btn:1'b1, clr:1'b0, cycles:3,  lvl:1'b0, rise:1'b0, fall:1'b0, press:8'd1};
        vecs[7] = '{btn:1'b0, clr:1'b0, cycles:2,  lvl:1'b0, rise:1'b0, fall:1'b0, press:8'd1};
        vecs[8] = '{btn:1'b1, clr:1'b0, cycles:3,  lvl:1'b0, rise:1'b0, fall:1'b0, press:8'd1};
        vecs[9] = '{btn:1'b0, clr:1'b0, cycles:8,  lvl:1'b0, rise:1'b0, fall:1'b0, press:8'd1};

        // Reset held while the button chatters: everything must stay cleared.
        rst_n      = 1'b0;
        bus.btn_in = 1'b0;
        bus.clr    = 1'b0;
        #1;
        checkOutput("reset_t0", 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            bus.btn_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checkOutput("reset_hold", 1'b0, 1'b0, 1'b0, 8'd0);
        end
        bus.btn_in = 1'b0;
        #3;
        rst_n = 1'b1;
        modelReset();

        // Clean press at edge 10, release at edge 30, then a bounce burst.
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < vecs[v].cycles; i++) applyStimulus(vecs[v].btn, vecs[v].clr);
            checkOutput($sformatf("vec%0d", v), vecs[v].lvl, vecs[v].rise, vecs[v].fall, vecs[v].press);
        end

        // Clear while idle, then wrap the counter through 255 back to 0.
        applyStimulus(1'b0, 1'b1);
        checkOutput("clr_idle", 1'b0, 1'b0, 1'b0, 8'd0);
        for (int n = 0; n < 255; n++) doPress();
        checkOutput("cnt_255", 1'b0, 1'b0, 1'b0, 8'd255);
        doPress();
        checkOutput("cnt_wrap", 1'b0, 1'b0, 1'b0, 8'd0);

        // Clear coinciding with a rise commit: pulse still fires, count stays 0.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("clr_on_rise", 1'b1, 1'b1, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("after_clr_rise", 1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("clr_release", 1'b0, 1'b0, 1'b0, 8'd0);
        doPress();
        checkOutput("press_after_clr", 1'b0, 1'b0, 1'b0, 8'd1);

        // Reset asserted mid-WAIT_HI with cnt=2, released with the button still held.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async", 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_mid_hold", 1'b0, 1'b0, 1'b0, 8'd0);
        end
        #3;
        rst_n = 1'b1;
        modelReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("rst_no_commit", 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("rst_recommit", 1'b1, 1'b1, 1'b0, 8'd1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0);

        // Random bursts of held levels and occasional clears against the model.
        for (int b = 0; b < 200; b++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) applyStimulus(lvl, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Push-button conditioning stage that sits directly upstream of the team's `dff_asyn`/`dff_syn` flip-flop stages. It synchronizes a raw, bouncy, asynchronous button input into the `clk` domain and debounces it with a stability counter. It then drives a clean registered level, single-cycle rise/fall pulses and an 8-bit press counter, which downstream flip-flops consume as their `d`/enable inputs.

## Interface
- `CNT_MAX`, default 4: number of consecutive mismatching sampled cycles required to accept a new level; legal range 2..65535.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  reset, asynchronous assert, active-low; all state cleared while low.
- `btn_in`  input  1  raw button, asynchronous to `clk`, may bounce.
- `clr`  input  1  synchronous clear of `press_cnt`, active-high.
- `btn_level`  output  1  debounced level, registered.
- `btn_rise`  output  1  one-cycle pulse on accepted 0->1 transition, registered.
- `btn_fall`  output  1  one-cycle pulse on accepted 1->0 transition, registered.
- `press_cnt`  output  8  count of accepted rises, modulo 256, registered.

## Operation
- Synchronizer: two flops `s1 <= btn_in`, `s2 <= s1`; both reset to 0. Only `s2` feeds the FSM; `btn_in` is never used elsewhere.
- Debounce counter `cnt`: width `$clog2(CNT_MAX+1)`, resets to 0.
- FSM states: STABLE_LO (reset state), WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: if `s2`==1, go to WAIT_HI and set `cnt`<=1. Otherwise stay, with `cnt`<=0.
  - WAIT_HI: if `s2`==0, return to STABLE_LO and set `cnt`<=0 (bounce rejected). If `s2`==1 and `cnt`==CNT_MAX-1, commit: go to STABLE_HI, `btn_level`<=1, `btn_rise`<=1, `cnt`<=0. Otherwise `cnt`<=`cnt`+1.
  - STABLE_HI / WAIT_LO: mirror image, with the commit driving `btn_level`<=0 and `btn_fall`<=1.
- `btn_rise`/`btn_fall` are 0 in every cycle except the one following a commit edge. They are never both 1.
- `press_cnt`:
  - `clr`==1 at an edge: `press_cnt`<=0. Clear wins over a simultaneous rise commit.
  - Otherwise, a rise commit at that edge increments the count. 255 wraps to 0.
  - A fall commit never changes the count.
- Reset values: `btn_level`=0, `btn_rise`=0, `btn_fall`=0, `press_cnt`=0, state STABLE_LO, `cnt`=0, `s1`=`s2`=0.
- Reset mid-operation: `rst_n` low forces all reset values immediately, without waiting for a clock edge. Any pending WAIT is discarded. A button still held high after reset release is re-debounced from STABLE_LO and produces a fresh rise and count.

## Timing
- `btn_in` settles high before edge k and stays high:
  - `s1`=1 after edge k.
  - `s2`=1 after edge k+1.
  - WAIT_HI entered at edge k+2.
  - Commit at edge k+CNT_MAX+1.
- Accept latency is therefore CNT_MAX+1 edges from the first sampling edge. With CNT_MAX=4, `btn_level` and `btn_rise` rise after edge k+5, and `btn_rise` falls after edge k+6.
- Release latency is identical and symmetric.
- A pulse on `s2` shorter than CNT_MAX consecutive cycles never commits.
- `press_cnt` updates on the same edge as `btn_rise` asserts.
- All outputs are flop outputs; there is no combinational path from any input to any output.

## Test plan
- Reset: hold `rst_n`=0 while toggling `btn_in` and `clk` -> all outputs 0. Deassert `rst_n` with `btn_in`=0 -> outputs stay 0.
- Clean press, CNT_MAX=4: `btn_in` 0->1 before edge 10 and held -> `btn_level`=1 and `btn_rise`=1 after edge 15, `btn_rise`=0 after edge 16, `press_cnt`=1.
- Bounce rejection: `btn_in` high for 3 cycles, low for 2, high for 3, then low -> `btn_level` stays 0, no pulses, `press_cnt` unchanged.
- Release: from accepted high, `btn_in` 1->0 before edge 30 -> `btn_level`=0 and `btn_fall`=1 after edge 35 for exactly one cycle, `press_cnt` unchanged.
- Wrap and clear:
  - 256 clean presses -> `press_cnt` goes 255->0.
  - `clr`=1 on the rise-commit edge of the next press -> `press_cnt`=0, not 1, while `btn_rise`=1.
- Reset mid-WAIT: assert `rst_n`=0 while in WAIT_HI with `cnt`=2 -> outputs 0 immediately. Release reset with `btn_in` still high -> rise commits 5 edges after the first post-reset edge, and `press_cnt`=1.
